// File: rtl/conv_chan_sched.sv
// Channel scheduler for the shared conv engine: one engine pass per
// output channel, result held on a valid/ready handshake, watchdog on RUN.
module conv_chan_sched #(
  parameter int CHAN    = 10,
  parameter int CHAN_W  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              eng_start,
  output logic [CHAN_W-1:0] eng_chan,
  input  logic              eng_done,
  output logic              res_valid,
  output logic [CHAN_W-1:0] res_chan,
  input  logic              res_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              err
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHAN - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    // abort outranks every other input once a frame is running
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_LAUNCH;
            chan_d  = '0;
            err_d   = 1'b0;
          end
        end
        S_LAUNCH: begin
          state_d = S_RUN;
          wdog_d  = '0;
        end
        S_RUN: begin
          if (eng_done) begin
            state_d = S_HOLD;
          end else if (wdog_q == WD_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else if (wdog_q != '1) begin
            wdog_d = wdog_q + 1'b1;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            if (chan_q == LAST_CHAN) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LAUNCH;
              chan_d  = chan_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign eng_start  = (state_q == S_LAUNCH);
  assign res_valid  = (state_q == S_HOLD);
  assign frame_done = (state_q == S_DONE);
  assign err        = err_q;
  assign eng_chan   = busy ? chan_q : '0;
  assign res_chan   = res_valid ? chan_q : '0;

endmodule

// File: tb/tb_conv_chan_sched.sv
// Directed bench for conv_chan_sched: engine model, scoreboard queues,
// second instance with a short watchdog for timeout cases.
module tb_conv_chan_sched;

  localparam int LAT = 20;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic res_ready;
  logic eng_done;
  logic eng_model;
  logic eng_spur;
  logic eng_auto;
  logic mon_en;

  logic       eng_start, res_valid, busy, frame_done, err;
  logic [3:0] eng_chan, res_chan;
  logic       eng_start2, res_valid2, busy2, frame_done2, err2;
  logic [3:0] eng_chan2, res_chan2;

  int n_cmp;
  int n_err;
  int n_start;
  int n_res;
  int n_valid;
  int n_fd;
  int n_fd2;
  int pend;
  int s_start, s_res, s_valid, s_fd, s_fd2;

  logic [3:0] q_eng[$];
  logic [3:0] q_res[$];

  assign eng_done = eng_model | eng_spur;

  conv_chan_sched #(.CHAN(10), .CHAN_W(4), .TIMEOUT(4096)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .eng_start(eng_start), .eng_chan(eng_chan), .eng_done(eng_done),
    .res_valid(res_valid), .res_chan(res_chan), .res_ready(res_ready),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  conv_chan_sched #(.CHAN(10), .CHAN_W(4), .TIMEOUT(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .eng_start(eng_start2), .eng_chan(eng_chan2), .eng_done(eng_done),
    .res_valid(res_valid2), .res_chan(res_chan2), .res_ready(res_ready),
    .busy(busy2), .frame_done(frame_done2), .err(err2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // engine model: done pulse LAT cycles after each eng_start of dut
  initial begin
    eng_model = 1'b0;
    pend = 0;
    forever begin
      @(negedge clk);
      eng_model = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) eng_model = 1'b1;
      end
      if (eng_auto && eng_start) pend = LAT;
    end
  end

  // scoreboard / monitor on dut
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (frame_done) n_fd++;
      if (frame_done2) n_fd2++;
      if (mon_en) begin
        if (eng_start) begin
          n_start++;
          if (q_eng.size() == 0) check("eng_start_extra", 1, 0);
          else check("eng_chan_seq", 32'(eng_chan), 32'(q_eng.pop_front()));
        end
        if (res_valid) n_valid++;
        if (res_valid && res_ready) begin
          n_res++;
          if (q_res.size() == 0) check("res_extra", 1, 0);
          else check("res_chan_seq", 32'(res_chan), 32'(q_res.pop_front()));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit reached");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_frame();
    for (int i = 0; i < 10; i++) begin
      q_eng.push_back(4'(i));
      q_res.push_back(4'(i));
    end
  endtask

  task automatic flush();
    q_eng.delete();
    q_res.delete();
  endtask

  task automatic snap();
    s_start = n_start;
    s_res   = n_res;
    s_valid = n_valid;
    s_fd    = n_fd;
    s_fd2   = n_fd2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_eng_chan(input logic [3:0] ch);
    int   k;
    logic hit;
    hit = 1'b0;
    for (k = 0; k < 300; k++) begin
      if (eng_start && eng_chan == ch) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check("wait_eng_chan", 32'(hit), 1);
  endtask

  task automatic wait_valid();
    int   k;
    logic hit;
    hit = 1'b0;
    for (k = 0; k < 100; k++) begin
      if (res_valid) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check("wait_res_valid", 32'(hit), 1);
  endtask

  task automatic wait_fd();
    int   k;
    logic hit;
    hit = 1'b0;
    for (k = 0; k < 600; k++) begin
      if (frame_done) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check("wait_frame_done", 32'(hit), 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    n_start = 0; n_res = 0; n_valid = 0; n_fd = 0; n_fd2 = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    eng_spur = 1'b0; eng_auto = 1'b0; mon_en = 1'b1;
    steps(2);
    rst_n = 1'b1;
    check("rst_outs", 32'({eng_start, eng_chan, res_valid, res_chan,
                           busy, frame_done, err}), 0);
    check("rst_outs2", 32'({eng_start2, eng_chan2, res_valid2, res_chan2,
                            busy2, frame_done2, err2}), 0);

    // 1 nominal frame
    eng_auto = 1'b1; res_ready = 1'b1;
    push_frame(); snap();
    pulse_start();
    check("t1_eng_start", 32'(eng_start), 1);
    check("t1_eng_chan0", 32'(eng_chan), 0);
    wait_fd();
    check("t1_err", 32'(err), 0);
    step();
    check("t1_busy_after", 32'(busy), 0);
    check("t1_starts", 32'(n_start - s_start), 10);
    check("t1_results", 32'(n_res - s_res), 10);
    check("t1_valid_cyc", 32'(n_valid - s_valid), 10);
    check("t1_frame_done", 32'(n_fd - s_fd), 1);

    // 2 backpressure on channel 3
    push_frame(); snap();
    pulse_start();
    wait_eng_chan(4'd3);
    res_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", 32'(res_valid), 1);
      check("t2_hold_chan", 32'(res_chan), 3);
      check("t2_no_launch", 32'(eng_start), 0);
      step();
    end
    res_ready = 1'b1;
    check("t2_still_valid", 32'(res_valid), 1);
    step();
    check("t2_launch4", 32'(eng_start), 1);
    check("t2_chan4", 32'(eng_chan), 4);
    wait_fd();
    step();
    check("t2_results", 32'(n_res - s_res), 10);

    // 3 watchdog on the short-timeout instance
    mon_en = 1'b0; eng_auto = 1'b0; res_ready = 1'b0;
    snap();
    pulse_start();
    check("t3_launch2", 32'(eng_start2), 1);
    check("t3_err_clr", 32'(err2), 0);
    steps(16);
    check("t3_busy_r15", 32'(busy2), 1);
    check("t3_err_r15", 32'(err2), 0);
    step();
    check("t3_busy_to", 32'(busy2), 0);
    check("t3_err_to", 32'(err2), 1);
    pulse_start();
    check("t3_restart_err", 32'(err2), 0);
    check("t3_restart_chan", 32'(eng_chan2), 0);
    steps(16);
    eng_spur = 1'b1;
    step();
    eng_spur = 1'b0;
    check("t3_late_done_hold", 32'(res_valid2), 1);
    check("t3_late_done_err", 32'(err2), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_abort_busy", 32'(busy2), 0);
    check("t3_abort_err", 32'(err2), 0);
    check("t3_abort_busy1", 32'(busy), 0);
    check("t3_dut_err", 32'(err), 0);
    check("t3_no_fd2", 32'(n_fd2 - s_fd2), 0);

    // 4 abort during RUN of channel 4
    mon_en = 1'b1; eng_auto = 1'b1; res_ready = 1'b1;
    push_frame(); snap();
    pulse_start();
    wait_eng_chan(4'd4);
    steps(3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    flush();
    check("t4_busy", 32'(busy), 0);
    check("t4_valid", 32'(res_valid), 0);
    steps(25);
    check("t4_idle_done", 32'({busy, res_valid}), 0);
    check("t4_no_fd", 32'(n_fd - s_fd), 0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("t4_start_abort", 32'({busy, eng_start}), 0);
    push_frame(); snap();
    pulse_start();
    check("t4_restart_chan", 32'({eng_start, eng_chan}), 32'h10);
    wait_fd();
    step();
    check("t4_results", 32'(n_res - s_res), 10);

    // 5 reset during HOLD of channel 6
    push_frame();
    pulse_start();
    wait_eng_chan(4'd6);
    res_ready = 1'b0;
    wait_valid();
    check("t5_hold6", 32'(res_chan), 6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    flush();
    check("t5_rst_outs", 32'({eng_start, eng_chan, res_valid, res_chan,
                              busy, frame_done, err}), 0);
    steps(25);
    res_ready = 1'b1;
    push_frame(); snap();
    pulse_start();
    wait_fd();
    step();
    check("t5_results", 32'(n_res - s_res), 10);
    check("t5_starts", 32'(n_start - s_start), 10);

    // 6 spurious eng_done and start
    eng_spur = 1'b1;
    step();
    eng_spur = 1'b0;
    check("t6_idle_spur", 32'({busy, res_valid}), 0);
    push_frame(); snap();
    pulse_start();
    wait_eng_chan(4'd2);
    steps(3);
    pulse_start();
    check("t6_run_start", 32'({busy, eng_start, eng_chan}), 32'h22);
    wait_eng_chan(4'd5);
    res_ready = 1'b0;
    wait_valid();
    eng_spur = 1'b1;
    step();
    eng_spur = 1'b0;
    check("t6_hold_spur", 32'({res_valid, eng_start, res_chan}), 32'h25);
    step();
    check("t6_hold_spur2", 32'({res_valid, res_chan}), 32'h15);
    res_ready = 1'b1;
    wait_fd();
    step();
    check("t6_results", 32'(n_res - s_res), 10);
    check("t6_busy", 32'(busy), 0);
    check("t6_fd", 32'(n_fd - s_fd), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
